// File: rtl/multiply_pkg.sv
// Shared types and constants for the shift-add multiplier.
// Holds the control state encoding and the default operand width.
package multiply_pkg;

    localparam int WIDTH_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/multiply_datapath.sv
// Shift-add datapath: operand registers, accumulator and step counter.
// The next accumulator value is exposed so control can capture it on the final step.
module multiply_datapath
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] sum,
    output logic               last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] a_ext;
    logic [CW-1:0]      count;

    // Partial product for this step and final-step detection
    always_comb begin
        a_ext = {{WIDTH{1'b0}}, a};
        sum   = acc;
        if (b[0]) begin
            sum = acc + (a_ext << count);
        end
        last  = (count == CW'(WIDTH - 1));
    end

    // Operand capture on load, one shift-add iteration per step
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a     <= '0;
            b     <= '0;
            acc   <= '0;
            count <= '0;
        end else if (load) begin
            a     <= multiplicand;
            b     <= multiplier;
            acc   <= '0;
            count <= '0;
        end else if (step) begin
            acc   <= sum;
            b     <= b >> 1;
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multiply.sv
// Sequential unsigned multiplier: IDLE/RUN control around a shift-add datapath.
// Define MULTIPLY_DONE_PULSE_EN to add a one-cycle done output.
module multiply
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
`ifdef MULTIPLY_DONE_PULSE_EN
    ,
    output logic               done
`endif
);

    state_t             state;
    state_t             next;
    logic               load;
    logic               step;
    logic               finish;
    logic               last;
    logic [2*WIDTH-1:0] sum;

    multiply_datapath #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clock       (clock),
        .reset_n     (reset_n),
        .load        (load),
        .step        (step),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .sum         (sum),
        .last        (last)
    );

    // Next state and datapath controls; start is ignored while running
    always_comb begin
        next   = state;
        load   = 1'b0;
        step   = 1'b0;
        finish = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                    next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    finish = 1'b1;
                    next   = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    // State, busy flag and product register; product moves only on completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            product <= '0;
        end else begin
            state <= next;
            busy  <= (next == RUN);
            if (finish) begin
                product <= sum;
            end
        end
    end

`ifdef MULTIPLY_DONE_PULSE_EN
    // One-cycle pulse alongside the product update
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done <= 1'b0;
        end else begin
            done <= finish;
        end
    end
`endif

endmodule

// File: tb/tb_multiply.sv
// Self-checking bench for the shift-add multiplier.
// Scoreboard of expected products plus a cycle model of busy/product.
module tb_multiply;

    localparam int W  = 4;
    localparam int PW = 2 * W;

    logic          clock;
    logic          reset_n;
    logic          start;
    logic [W-1:0]  multiplicand;
    logic [W-1:0]  multiplier;
    logic [PW-1:0] product;
    logic          busy;
`ifdef MULTIPLY_DONE_PULSE_EN
    logic          done;
`endif

    int tests;
    int fails;

    logic [PW-1:0] sb[$];
    int            mcnt;
    logic [PW-1:0] mcur;
    logic [PW-1:0] mprod;
    logic          mdone;
    logic          prev_busy;
    int            busy_len;

    multiply #(
        .WIDTH(W)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .product     (product),
        .busy        (busy)
`ifdef MULTIPLY_DONE_PULSE_EN
        ,
        .done        (done)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: accepts start when idle, completes W edges later
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcnt  <= 0;
            mcur  <= '0;
            mprod <= '0;
            mdone <= 1'b0;
            sb.delete();
        end else begin
            mdone <= 1'b0;
            if (mcnt != 0) begin
                mcnt <= mcnt - 1;
                if (mcnt == 1) begin
                    mprod <= mcur;
                    mdone <= 1'b1;
                end
            end else if (start) begin
                mcnt <= W;
                mcur <= PW'(multiplicand) * PW'(multiplier);
                sb.push_back(PW'(multiplicand) * PW'(multiplier));
            end
        end
    end

    // Compare DUT against model away from the active edge
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_busy = 1'b0;
            busy_len  = 0;
        end else begin
            check("busy", 64'(busy), 64'(mcnt != 0));
            check("product_hold", 64'(product), 64'(mprod));
`ifdef MULTIPLY_DONE_PULSE_EN
            check("done", 64'(done), 64'(mdone));
`endif
            if (busy) begin
                busy_len++;
            end else if (prev_busy) begin
                check("busy_len", 64'(busy_len), 64'(W));
                if (sb.size() == 0) begin
                    check("sb_empty", 64'(1), 64'(0));
                end else begin
                    check("sb_product", 64'(product), 64'(sb.pop_front()));
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        step();
        start        = 1'b0;
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        repeat (W) step();
        check("op_result", 64'(product), 64'(PW'(a) * PW'(b)));
        check("op_idle", 64'(busy), 64'(0));
    endtask

    initial begin
        tests        = 0;
        fails        = 0;
        reset_n      = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #2;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_product", 64'(product), 64'(0));
        step();
        step();
        #3;
        reset_n = 1'b1;
        step();

        run_op(4'd4, 4'd3);
        run_op(4'd15, 4'd15);
        run_op(4'd0, 4'd9);
        run_op(4'd9, 4'd0);
        step();

        // Start ignored while busy, operand changes ignored
        multiplicand = 4'd5;
        multiplier   = 4'd6;
        start        = 1'b1;
        step();
        multiplicand = 4'd7;
        multiplier   = 4'd7;
        step();
        step();
        start = 1'b0;
        repeat (W - 1) step();
        check("ignore_start", 64'(product), 64'(30));
        step();

        // Reset mid-operation
        multiplicand = 4'd9;
        multiplier   = 4'd9;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_product", 64'(product), 64'(0));
        step();
        step();
        #2;
        reset_n = 1'b1;
        step();
        run_op(4'd2, 4'd3);
        step();

        // Start held high: back-to-back with one idle cycle between
        multiplicand = 4'd3;
        multiplier   = 4'd5;
        start        = 1'b1;
        repeat (3 * (W + 1)) step();
        start = 1'b0;
        repeat (W + 2) step();
        check("b2b_product", 64'(product), 64'(15));

        // Exhaustive operand sweep
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                run_op(W'(i), W'(j));
            end
        end
        repeat (2) step();
        check("sb_drained", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiply.md
MULTIPLY -- requirements
Module: multiply

Interface
REQ-001 Parameter WIDTH, default 4: operand width in bits; product width is 2*WIDTH.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a multiplication; sampled on a rising clock edge.
REQ-005 multiplicand  input  WIDTH  unsigned operand A; sampled only on an accepted start.
REQ-006 multiplier  input  WIDTH  unsigned operand B; sampled only on an accepted start.
REQ-007 product  output  2*WIDTH  unsigned A*B; registered.
REQ-008 busy  output  1  high while a multiplication is in progress; registered.

Function
REQ-009 The FSM SHALL have two states: IDLE and RUN.
REQ-010 In IDLE with start=1 at a rising edge, the block SHALL latch multiplicand and multiplier, clear the accumulator and iteration counter, enter RUN, and set busy=1.
REQ-011 Each RUN cycle SHALL perform one shift-add step: if the current multiplier LSB is 1, add (A << count) to the 2*WIDTH-bit accumulator; shift multiplier right by 1; increment count.
REQ-012 After exactly WIDTH RUN cycles, the block SHALL load the accumulator into product, clear busy, and return to IDLE.
REQ-013 Latency: with start accepted at edge N, busy SHALL be high after edges N through N+WIDTH-1; product SHALL be valid and busy low after edge N+WIDTH.
REQ-014 product SHALL hold its previous value throughout RUN and SHALL change only at completion or on reset.
REQ-015 Arithmetic SHALL be unsigned and exact. No overflow is possible: the maximum result (2^WIDTH-1)^2 fits in 2*WIDTH bits.
REQ-016 start while busy=1 SHALL be ignored; the operation in flight SHALL complete unaffected.
REQ-017 Operand changes while busy=1 SHALL NOT affect the result.
REQ-018 start held high continuously SHALL launch a new operation on the first edge after return to IDLE, giving back-to-back operations one idle cycle apart.
REQ-019 Zero operands SHALL still take the full WIDTH cycles and SHALL yield product=0.

Reset
REQ-020 reset_n=0 SHALL immediately force state=IDLE, busy=0, product=0, and clear the accumulator, counter and operand registers, independent of clock.
REQ-021 Reset asserted mid-operation SHALL abort the operation with no partial result visible on product.
REQ-022 After reset_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Configuration
REQ-023 With macro MULTIPLY_DONE_PULSE_EN defined, the block SHALL add output port done (1 bit, registered), high for exactly one cycle after the edge at which product is updated, and 0 during reset.
REQ-024 Without MULTIPLY_DONE_PULSE_EN, the done port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package multiply_pkg SHALL hold the state enumeration type (IDLE, RUN) and the default WIDTH constant.
REQ-026 The shift-add datapath (operand registers, accumulator, counter) SHALL be a sub-module named multiply_datapath, with control in multiply.

Verification
REQ-027 Reset, then multiplicand=4, multiplier=3, 1-cycle start pulse -> busy high exactly 4 cycles, then product=12, busy=0.
REQ-028 multiplicand=15, multiplier=15, start -> product=225 after 4 cycles; multiplicand=0, multiplier=9 -> product=0 after the same 4-cycle latency.
REQ-029 Start 5*6, then pulse start with 7*7 and change operands while busy -> product=30; the second request is ignored.
REQ-030 Start 9*9, assert reset_n=0 after 2 cycles -> busy=0 and product=0 immediately; after release, 2*3 -> 6.
REQ-031 start held high with operands 3*5 -> repeated results of 15, each busy period 4 cycles, separated by one idle cycle.
REQ-032 With MULTIPLY_DONE_PULSE_EN defined, 4*3 -> done high for one cycle coincident with product=12; exhaustive 16x16 operand sweep matches the reference product.
